// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl -- bit-serial adder controller (one full-adder slice, LSB first)
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             s_bit, c_bit;

   // The single full-adder slice shared across all bit positions.
   always_comb begin
      s_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      c_bit = (a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & carry_q) | (carry_q & a_sh_q[0]);
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a_in;
               b_sh_d  = b_in;
               carry_d = cin_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            res_d   = {s_bit, res_q[WIDTH-1:1]};
            carry_d = c_bit;
            cnt_d   = cnt_q + CW'(1);
            // Last slice: the result register is only complete including this bit.
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = {s_bit, res_q[WIDTH-1:1]};
               cout_d  = c_bit;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign sum_out = sum_q;
   assign cout    = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// tb_serial_adder_ctrl -- directed self-checking bench for serial_adder_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;
   logic       cin_in = 1'b0;
   logic       busy, done, cout;
   logic [7:0] sum_out;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       cin4 = 1'b0;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;

   int tests = 0;
   int fails = 0;
   logic [7:0] last_sum = 8'h00;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
      .cin_in(cin_in), .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
   );

   serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4),
      .cin_in(cin4), .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge with the WIDTH=8 DUT idle.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] exp_sum, input logic exp_cout,
                       input int inject_at, input string tag);
      int edges;
      int busy_n;
      logic overlap;
      start = 1'b1; a_in = a; b_in = b; cin_in = ci;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 0; busy_n = 0; overlap = 1'b0;
      while (!done && edges < 20) begin
         if (busy) busy_n++;
         if (edges == 4) chk({tag, "_hold"}, {24'h0, sum_out}, {24'h0, last_sum});
         if (edges == inject_at) begin
            start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         edges++;
      end
      start = 1'b0;
      overlap = busy & done;
      chk({tag, "_latency"}, edges, 8);
      chk({tag, "_busycyc"}, busy_n, 8);
      chk({tag, "_overlap"}, {31'h0, overlap}, 0);
      chk({tag, "_sum"}, {24'h0, sum_out}, {24'h0, exp_sum});
      chk({tag, "_cout"}, {31'h0, cout}, {31'h0, exp_cout});
      last_sum = exp_sum;
      @(posedge clk); #1;
      chk({tag, "_donepulse"}, {30'h0, done, busy}, 0);
   endtask

   initial begin
      int edges;
      logic seen_done;
      logic [4:0] exp5;

      #2;
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_done", {31'h0, done}, 0);
      chk("rst_sum",  {24'h0, sum_out}, 0);
      chk("rst_cout", {31'h0, cout}, 0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, -1, "zero");
      run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1, "ff_01");
      run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, -1, "a5_5a_c");
      run8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 3, "3c_0f_inj");
      run8(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, -1, "small");

      // Asynchronous reset in the middle of a run.
      start = 1'b1; a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'h0, busy}, 0);
      chk("midrst_done", {31'h0, done}, 0);
      chk("midrst_sum",  {24'h0, sum_out}, 0);
      chk("midrst_cout", {31'h0, cout}, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done | busy) seen_done = 1'b1;
      end
      chk("midrst_nodone", {31'h0, seen_done}, 0);
      last_sum = 8'h00;
      run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, -1, "after_rst");

      // WIDTH=4 exhaustive sweep, each start issued on the first IDLE cycle.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               a4 = 4'(ia); b4 = 4'(ib); cin4 = ic[0];
               exp5 = 5'(ia + ib + ic);
               start4 = 1'b1;
               @(posedge clk); #1;
               start4 = 1'b0;
               edges = 0;
               while (!done4 && edges < 12) begin
                  @(posedge clk); #1;
                  edges++;
               end
               chk("w4_result", {26'h0, edges == 4, cout4, sum4}, {26'h0, 1'b1, exp5});
               @(posedge clk); #1;
               chk("w4_pulse", {31'h0, done4}, 0);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
